// File: rtl/branch_predict_table.sv
// -----------------------------------------------------------------------------
// branch_predict_table
//   Direct-mapped branch target predictor with 2-bit saturating counters and an
//   optional speculative return-address stack (RAS).
//
//   Optional feature macro: BPU_RAS_EN
//     defined   -> RAS storage is built; taken returns predict from the RAS top
//     undefined -> no RAS; returns predict from the table entry's target
//
// Ports
//   clk                   : clock, all state updates on rising edge
//   rst                   : synchronous active-high reset
//   IF_PC                 : fetch PC being looked up
//   IF_Req                : lookup valid this cycle
//   IF_Stall              : fetch held, suppresses speculative RAS push/pop
//   IF_PResult            : combinational prediction for IF_PC
//   EXE_BResult           : resolved branch information from EXE
//   EXE_Prediction_Failed : EXE misprediction flag, repairs the RAS
// -----------------------------------------------------------------------------
package bpu_pkg;

    typedef enum logic [1:0] {
        BIsImme = 2'd0,
        BIsCall = 2'd1,
        BIsRetn = 2'd2,
        BIsReg  = 2'd3
    } btype_e;

    typedef struct packed {
        logic        Valid;
        logic        Hit;
        logic        Taken;
        logic [1:0]  Count;
        btype_e      Type;
        logic [31:0] Target;
    } PResult;

    typedef struct packed {
        logic        Valid;
        logic        Hit;
        logic [31:0] PC;
        logic        IsTaken;
        btype_e      Type;
        logic [31:0] Target;
        logic [1:0]  Count;
    } BResult;

endpackage

module branch_predict_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_PC,
    input  logic        IF_Req,
    input  logic        IF_Stall,
    output PResult      IF_PResult,
    input  BResult      EXE_BResult,
    input  logic        EXE_Prediction_Failed
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    // ------------------------------------------------------------------
    // Predictor table storage. Only the valid bits are reset.
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q    [ENTRIES];
    btype_e             type_q   [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup (pre-update contents, no bypass from the EXE write port)
    // ------------------------------------------------------------------
    logic [IW-1:0] if_idx;
    logic [TW-1:0] if_tag;
    logic [31:0]   pc_plus8;
    logic          lu_hit;
    logic [1:0]    lu_cnt;
    btype_e        lu_type;
    logic          lu_taken;
    logic [31:0]   lu_target;

    assign if_idx   = IF_PC[IW+1:2];
    assign if_tag   = IF_PC[31:IW+2];
    assign pc_plus8 = IF_PC + 32'd8;

    assign lu_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign lu_cnt   = lu_hit ? cnt_q[if_idx] : 2'b01;
    assign lu_type  = lu_hit ? type_q[if_idx] : BIsImme;
    // Calls and returns are unconditional, so they predict taken on any hit.
    assign lu_taken = lu_hit && (lu_cnt[1] || lu_type == BIsCall || lu_type == BIsRetn);

`ifdef BPU_RAS_EN
    // ------------------------------------------------------------------
    // Return-address stack: circular buffer. ras_ptr_q is the next write
    // slot, so the top of stack lives at ras_ptr_q-1. When full, a push
    // lands on the oldest entry and the count stays saturated.
    // ------------------------------------------------------------------
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    logic [31:0]   ras_mem_q [RAS_DEPTH];
    logic [PW-1:0] ras_ptr_q, ras_ptr_d;
    logic [CW-1:0] ras_cnt_q, ras_cnt_d;
    logic          ras_we;
    logic [31:0]   ras_wdata;
    logic [31:0]   ras_top;
    logic          if_go;

    assign ras_top = ras_mem_q[ras_ptr_q - PW'(1)];
    assign if_go   = IF_Req && !IF_Stall && lu_taken;

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we    = 1'b0;
        ras_wdata = pc_plus8;
        // Repair wins over any speculative IF activity in the same cycle.
        if (EXE_Prediction_Failed) begin
            ras_cnt_d = '0;
            if (EXE_BResult.Type == BIsCall && EXE_BResult.IsTaken) begin
                ras_we    = 1'b1;
                ras_wdata = EXE_BResult.PC + 32'd8;
                ras_ptr_d = ras_ptr_q + PW'(1);
                ras_cnt_d = CW'(1);
            end
        end else if (if_go && lu_type == BIsCall) begin
            ras_we    = 1'b1;
            ras_ptr_d = ras_ptr_q + PW'(1);
            if (ras_cnt_q != RAS_FULL) begin
                ras_cnt_d = ras_cnt_q + CW'(1);
            end
        end else if (if_go && lu_type == BIsRetn && ras_cnt_q != '0) begin
            ras_ptr_d = ras_ptr_q - PW'(1);
            ras_cnt_d = ras_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ras_we) begin
            ras_mem_q[ras_ptr_q] <= ras_wdata;
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{IF_Stall, EXE_Prediction_Failed, EXE_BResult.PC[1:0]};
`endif

    always_comb begin
        lu_target = pc_plus8;
        if (lu_taken) begin
            lu_target = target_q[if_idx];
`ifdef BPU_RAS_EN
            if (lu_type == BIsRetn && ras_cnt_q != '0) begin
                lu_target = ras_top;
            end
`endif
        end
    end

    always_comb begin
        IF_PResult        = '0;
        IF_PResult.Valid  = IF_Req;
        IF_PResult.Hit    = lu_hit;
        IF_PResult.Taken  = lu_taken;
        IF_PResult.Count  = lu_cnt;
        IF_PResult.Type   = lu_type;
        IF_PResult.Target = lu_target;
    end

    // ------------------------------------------------------------------
    // EXE update. A resolved hit retrains the entry; a miss allocates only
    // when the branch was actually taken.
    // ------------------------------------------------------------------
    logic [IW-1:0] ex_idx;
    logic [TW-1:0] ex_tag;
    logic          ex_we;
    logic [1:0]    ex_cnt;

    assign ex_idx = EXE_BResult.PC[IW+1:2];
    assign ex_tag = EXE_BResult.PC[31:IW+2];
    assign ex_we  = EXE_BResult.Valid && (EXE_BResult.Hit || EXE_BResult.IsTaken);

    always_comb begin
        ex_cnt = 2'b10;
        if (EXE_BResult.Hit) begin
            if (EXE_BResult.IsTaken) begin
                ex_cnt = (EXE_BResult.Count == 2'b11) ? 2'b11 : EXE_BResult.Count + 2'd1;
            end else begin
                ex_cnt = (EXE_BResult.Count == 2'b00) ? 2'b00 : EXE_BResult.Count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (ex_we) begin
            valid_q[ex_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ex_we) begin
            tag_q[ex_idx]    <= ex_tag;
            type_q[ex_idx]   <= EXE_BResult.Type;
            target_q[ex_idx] <= EXE_BResult.Target;
            cnt_q[ex_idx]    <= ex_cnt;
        end
    end

endmodule

// File: tb/tb_branch_predict_table.sv
module tb_branch_predict_table;
    import bpu_pkg::*;

    localparam int ENTRIES   = 64;
    localparam int RAS_DEPTH = 8;
    localparam int IW        = $clog2(ENTRIES);
`ifdef BPU_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_req;
    logic        if_stall;
    PResult      presult;
    BResult      bres;
    logic        fail;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predict_table #(.ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .IF_PC                 (if_pc),
        .IF_Req                (if_req),
        .IF_Stall              (if_stall),
        .IF_PResult            (presult),
        .EXE_BResult           (bres),
        .EXE_Prediction_Failed (fail)
    );

    // ---------------- reference model ----------------
    // Table as plain arrays keyed by index; RAS as an unbounded queue that
    // forgets its oldest element once it grows past RAS_DEPTH.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [1:0]  m_type  [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_ras [$];

    function automatic void m_lookup(input logic [31:0] pc, output bit hit, output int cnt,
                                     output logic [1:0] typ, output bit taken, output logic [31:0] tgt);
        int idx;
        idx   = int'((pc >> 2) % ENTRIES);
        hit   = m_valid[idx] && (m_tag[idx] == (pc >> (IW + 2)));
        cnt   = hit ? m_cnt[idx] : 1;
        typ   = m_type[idx];
        taken = hit && (cnt >= 2 || typ == BIsCall || typ == BIsRetn);
        if (!taken)
            tgt = pc + 32'd8;
        else if (RAS_EN && typ == BIsRetn && m_ras.size() > 0)
            tgt = m_ras[$];
        else
            tgt = m_tgt[idx];
    endfunction

    function automatic void m_update();
        bit hit, taken;
        int cnt, idx;
        logic [1:0] typ;
        logic [31:0] tgt;
        if (rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_ras.delete();
            return;
        end
        m_lookup(if_pc, hit, cnt, typ, taken, tgt);
        if (RAS_EN) begin
            if (fail) begin
                m_ras.delete();
                if (bres.Type == BIsCall && bres.IsTaken) m_ras.push_back(bres.PC + 32'd8);
            end else if (if_req && !if_stall && taken) begin
                if (typ == BIsCall) begin
                    m_ras.push_back(if_pc + 32'd8);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end else if (typ == BIsRetn && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
        if (bres.Valid && (bres.Hit || bres.IsTaken)) begin
            idx = int'((bres.PC >> 2) % ENTRIES);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = bres.PC >> (IW + 2);
            m_type[idx]  = bres.Type;
            m_tgt[idx]   = bres.Target;
            if (!bres.Hit)        m_cnt[idx] = 2;
            else if (bres.IsTaken) m_cnt[idx] = (int'(bres.Count) + 1 > 3) ? 3 : int'(bres.Count) + 1;
            else                  m_cnt[idx] = (int'(bres.Count) - 1 < 0) ? 0 : int'(bres.Count) - 1;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic hit, input logic [31:0] pc, input logic tk,
                          input btype_e typ, input logic [31:0] tgt, input logic [1:0] cnt);
        bres.Valid = v; bres.Hit = hit; bres.PC = pc; bres.IsTaken = tk;
        bres.Type = typ; bres.Target = tgt; bres.Count = cnt;
    endtask

    task automatic expect_lu(input string nm, input bit ehit, input logic [1:0] ecnt,
                             input bit etk, input logic [31:0] etgt);
        @(negedge clk);
        chk({nm, ".valid"},  32'(presult.Valid), 32'(if_req));
        chk({nm, ".hit"},    32'(presult.Hit),   32'(ehit));
        chk({nm, ".count"},  32'(presult.Count), 32'(ecnt));
        chk({nm, ".taken"},  32'(presult.Taken), 32'(etk));
        chk({nm, ".target"}, presult.Target,     etgt);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic stall);
        if_pc = pc; if_req = 1'b1; if_stall = stall;
    endtask

    function automatic logic [31:0] pick_pc();
        return 32'h8000_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2);
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] pc;
        logic        bv, bhit, btk;
        btype_e      btype;
        logic [31:0] bpc, btgt;
        logic [1:0]  bcnt;
        logic        chk;
        logic        ehit;
        logic [1:0]  ecnt;
        logic        etk;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mkv(logic r, logic req, logic [31:0] pc,
                                 logic bv, logic bhit, logic [31:0] bpc, logic btk, btype_e bt,
                                 logic [31:0] btgt, logic [1:0] bcnt,
                                 logic c, logic eh, logic [1:0] ec, logic etk, logic [31:0] etgt);
        vec_t v;
        v.rst = r; v.req = req; v.pc = pc; v.bv = bv; v.bhit = bhit; v.bpc = bpc; v.btk = btk;
        v.btype = bt; v.btgt = btgt; v.bcnt = bcnt; v.chk = c; v.ehit = eh; v.ecnt = ec;
        v.etk = etk; v.etgt = etgt;
        return v;
    endfunction

    localparam logic [31:0] PA = 32'h8000_0100;
    localparam logic [31:0] TA = 32'h8000_0200;

    initial begin
        bit          h, tk;
        int          c;
        logic [1:0]  ty;
        logic [31:0] tg, exp_t;

        rst = 1'b1; if_pc = '0; if_req = 1'b0; if_stall = 1'b0; fail = 1'b0;
        set_ex(0, 0, 0, 0, BIsImme, 0, 0);

        // reset, lookup after reset
        vecs.push_back(mkv(1, 1, 32'h8000_0010, 0,0,0,0,BIsImme,0,0, 0, 0,2'b01,0,32'h8000_0018));
        vecs.push_back(mkv(0, 1, 32'h8000_0010, 0,0,0,0,BIsImme,0,0, 1, 0,2'b01,0,32'h8000_0018));
        // allocate (same-cycle lookup sees old contents), then hit
        vecs.push_back(mkv(0, 1, PA, 1,0,PA,1,BIsImme,TA,2'b00, 1, 0,2'b01,0,32'h8000_0108));
        vecs.push_back(mkv(0, 1, PA, 0,0,0,0,BIsImme,0,0,       1, 1,2'b10,1,TA));
        // five taken resolutions
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,1,BIsImme,TA,2'b10, 1, 1,2'b10,1,TA));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,1,BIsImme,TA,2'b11, 1, 1,2'b11,1,TA));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,1,BIsImme,TA,2'b11, 1, 1,2'b11,1,TA));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,1,BIsImme,TA,2'b11, 1, 1,2'b11,1,TA));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,1,BIsImme,TA,2'b11, 1, 1,2'b11,1,TA));
        // four not-taken resolutions
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,0,BIsImme,TA,2'b11, 1, 1,2'b11,1,TA));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,0,BIsImme,TA,2'b10, 1, 1,2'b10,1,TA));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,0,BIsImme,TA,2'b01, 1, 1,2'b01,0,32'h8000_0108));
        vecs.push_back(mkv(0, 1, PA, 1,1,PA,0,BIsImme,TA,2'b00, 1, 1,2'b00,0,32'h8000_0108));
        // not-taken miss must not touch the entry
        vecs.push_back(mkv(0, 0, PA, 1,0,PA,0,BIsCall,32'hDEAD_BEEF,2'b00, 1, 1,2'b00,0,32'h8000_0108));
        vecs.push_back(mkv(0, 1, PA, 0,0,0,0,BIsImme,0,0,       1, 1,2'b00,0,32'h8000_0108));
        // mid-stream reset with a concurrent allocation that must be ignored
        vecs.push_back(mkv(1, 1, PA, 1,0,32'h8000_0500,1,BIsImme,32'h8000_0900,2'b00, 0, 0,0,0,0));
        vecs.push_back(mkv(0, 1, PA, 0,0,0,0,BIsImme,0,0,       1, 0,2'b01,0,32'h8000_0108));
        vecs.push_back(mkv(0, 1, 32'h8000_0500, 0,0,0,0,BIsImme,0,0, 1, 0,2'b01,0,32'h8000_0508));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; if_req = vecs[i].req; if_pc = vecs[i].pc; if_stall = 1'b0;
            set_ex(vecs[i].bv, vecs[i].bhit, vecs[i].bpc, vecs[i].btk, vecs[i].btype,
                   vecs[i].btgt, vecs[i].bcnt);
            if (vecs[i].chk) expect_lu($sformatf("vec%0d", i), vecs[i].ehit, vecs[i].ecnt,
                                       vecs[i].etk, vecs[i].etgt);
            tick();
        end
        rst = 1'b0;

        // ---------------- call / return ----------------
        if_req = 1'b0;
        set_ex(1, 0, 32'h8000_0300, 1, BIsCall, 32'h8000_1000, 2'b00); tick();
        set_ex(1, 0, 32'h8000_0680, 1, BIsRetn, 32'h0000_0000, 2'b00); tick();
        set_ex(0, 0, 0, 0, BIsImme, 0, 0);
        lookup(32'h8000_0300, 0); expect_lu("call", 1, 2'b10, 1, 32'h8000_1000); tick();
        lookup(32'h8000_0680, 0);
        expect_lu("ret", 1, 2'b10, 1, RAS_EN ? 32'h8000_0308 : 32'h0); tick();
        lookup(32'h8000_0680, 0); expect_lu("ret_empty", 1, 2'b10, 1, 32'h0); tick();
        lookup(32'h8000_0300, 1); expect_lu("call_stall", 1, 2'b10, 1, 32'h8000_1000); tick();
        lookup(32'h8000_0680, 0); expect_lu("ret_after_stall", 1, 2'b10, 1, 32'h0); tick();

        // ---------------- RAS overflow ----------------
        if_req = 1'b0;
        for (int i = 0; i < RAS_DEPTH + 1; i++) begin
            set_ex(1, 0, 32'h8000_0804 + 32'(4 * i), 1, BIsCall, 32'h9000_0000 + 32'(16 * i), 2'b00);
            tick();
        end
        set_ex(0, 0, 0, 0, BIsImme, 0, 0);
        for (int i = 0; i < RAS_DEPTH + 1; i++) begin
            lookup(32'h8000_0804 + 32'(4 * i), 0);
            expect_lu($sformatf("ovf_call%0d", i), 1, 2'b10, 1, 32'h9000_0000 + 32'(16 * i));
            tick();
        end
        for (int k = 0; k < RAS_DEPTH + 1; k++) begin
            lookup(32'h8000_0680, 0);
            exp_t = (RAS_EN && k < RAS_DEPTH) ? 32'h8000_080C + 32'(4 * (RAS_DEPTH - k)) : 32'h0;
            expect_lu($sformatf("ovf_ret%0d", k), 1, 2'b10, 1, exp_t);
            tick();
        end

        // ---------------- repair vs same-cycle push ----------------
        lookup(32'h8000_0804, 0); tick();
        lookup(32'h8000_0300, 0); tick();
        lookup(32'h8000_0300, 0); fail = 1'b1;
        set_ex(1, 0, 32'h8000_0400, 1, BIsCall, 32'h8000_2000, 2'b00);
        expect_lu("repair_call", 1, 2'b10, 1, 32'h8000_1000); tick();
        fail = 1'b0; set_ex(0, 0, 0, 0, BIsImme, 0, 0);
        lookup(32'h8000_0680, 0);
        expect_lu("repair_top", 1, 2'b10, 1, RAS_EN ? 32'h8000_0408 : 32'h0); tick();
        lookup(32'h8000_0680, 0); expect_lu("repair_cnt1", 1, 2'b10, 1, 32'h0); tick();
        lookup(32'h8000_0300, 0); expect_lu("repair_evict", 0, 2'b01, 0, 32'h8000_0308); tick();

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            if_pc    = pick_pc();
            if_req   = ($urandom_range(0, 3) != 0);
            if_stall = ($urandom_range(0, 3) == 0);
            fail     = ($urandom_range(0, 7) == 0);
            bres.PC  = pick_pc();
            m_lookup(bres.PC, h, c, ty, tk, tg);
            bres.Valid   = $urandom_range(0, 1) == 1;
            bres.Hit     = h;
            bres.Count   = h ? 2'(c) : 2'($urandom_range(0, 3));
            bres.IsTaken = $urandom_range(0, 1) == 1;
            bres.Type    = btype_e'($urandom_range(0, 3));
            bres.Target  = {$urandom(), 2'b00} >> 2 | 32'h8000_0000;
            m_lookup(if_pc, h, c, ty, tk, tg);
            expect_lu("rand", h, 2'(c), tk, tg);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
